dvi_pattern_sched: RTL and testbench

//  Pixel-clock-domain sequencer for the DVI test-pattern path. Gates the link

---
 rtl/dvi_pkg.sv | 13 +
 rtl/vsync_edge_det.sv | 27 ++
 rtl/dvi_pattern_sched.sv | 142 ++++++++++++++
 tb/tb_dvi_pattern_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - shared types and defaults for the DVI test-pattern path
package dvi_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_WARMUP    = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    localparam int DEF_NUM_PATTERNS = 8;
    localparam int DEF_PAT_W        = 3;

endpackage

// File: rtl/vsync_edge_det.sv
// rtl/vsync_edge_det.sv - vsync rising-edge detector producing a one-cycle frame boundary
module vsync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vsync,
    output logic o_fb
);

    logic vs_q;
    logic vs_d;

    always_comb begin
        vs_d = i_vsync;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vs_d;
        end
    end

    // Combinational against the registered copy so the boundary is seen in the rising cycle
    assign o_fb = i_vsync & ~vs_q;

endmodule

// File: rtl/dvi_pattern_sched.sv
// rtl/dvi_pattern_sched.sv - lock gating, warmup blanking and frame-aligned pattern selection
module dvi_pattern_sched
    import dvi_pkg::*;
#(
    parameter int NUM_PATTERNS   = DEF_NUM_PATTERNS,
    parameter int PAT_W          = DEF_PAT_W,
    parameter int FRAMES_PER_PAT = 60,
    parameter int WARMUP_FRAMES  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_locked,
    input  logic             i_vsync,
    input  logic             i_auto_en,
    input  logic             i_sel_req,
    input  logic [PAT_W-1:0] i_sel_pat,
    output logic [PAT_W-1:0] o_pattern,
    output logic             o_force_blank,
    output logic             o_link_up,
    output logic             o_sel_ack,
    output logic             o_sel_err
);

    localparam int WARM_W  = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;
    localparam int DWELL_W = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
    localparam logic [WARM_W-1:0]  WARM_LAST  = WARM_W'(WARMUP_FRAMES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(FRAMES_PER_PAT - 1);
    localparam logic [PAT_W-1:0]   PAT_LAST   = PAT_W'(NUM_PATTERNS - 1);

    state_e               state_q, state_d;
    logic [WARM_W-1:0]    warm_cnt_q, warm_cnt_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [PAT_W-1:0]     pattern_q, pattern_d;
    logic                 pend_q, pend_d;
    logic [PAT_W-1:0]     pend_pat_q, pend_pat_d;
    logic                 wait_low_q, wait_low_d;
    logic                 sel_ack_q, sel_ack_d;
    logic                 sel_err_q, sel_err_d;

    logic fb;
    logic run_fb;
    logic pend_ok;
    logic apply;

    vsync_edge_det u_vsync_edge_det (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_vsync (i_vsync),
        .o_fb    (fb)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_WAIT_LOCK;
            warm_cnt_q  <= '0;
            dwell_cnt_q <= '0;
            pattern_q   <= '0;
            pend_q      <= 1'b0;
            pend_pat_q  <= '0;
            wait_low_q  <= 1'b0;
            sel_ack_q   <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            pattern_q   <= pattern_d;
            pend_q      <= pend_d;
            pend_pat_q  <= pend_pat_d;
            wait_low_q  <= wait_low_d;
            sel_ack_q   <= sel_ack_d;
            sel_err_q   <= sel_err_d;
        end
    end

    // Loss of lock overrides every state, including a pending warmup exit
    always_comb begin
        state_d = state_q;
        if (!i_locked) begin
            state_d = ST_WAIT_LOCK;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: state_d = ST_WARMUP;
                ST_WARMUP:    if (fb && (warm_cnt_q == WARM_LAST)) state_d = ST_RUN;
                default:      state_d = state_q;
            endcase
        end
    end

    always_comb begin
        run_fb  = i_locked && (state_q == ST_RUN) && fb;
        pend_ok = int'(pend_pat_q) < NUM_PATTERNS;
        apply   = run_fb && pend_q && pend_ok;

        warm_cnt_d = warm_cnt_q;
        if (state_q != ST_WARMUP) begin
            warm_cnt_d = '0;
        end else if (fb) begin
            warm_cnt_d = (warm_cnt_q == WARM_LAST) ? '0 : warm_cnt_q + WARM_W'(1);
        end

        // Dwell is held at zero outside RUN so every RUN entry starts a fresh dwell
        dwell_cnt_d = dwell_cnt_q;
        pattern_d   = pattern_q;
        if (state_q != ST_RUN) begin
            dwell_cnt_d = '0;
        end else if (apply) begin
            pattern_d   = pend_pat_q;
            dwell_cnt_d = '0;
        end else if (run_fb && i_auto_en) begin
            if (dwell_cnt_q == DWELL_LAST) begin
                dwell_cnt_d = '0;
                pattern_d   = (pattern_q == PAT_LAST) ? '0 : pattern_q + PAT_W'(1);
            end else begin
                dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
            end
        end

        sel_ack_d  = run_fb && pend_q;
        sel_err_d  = sel_ack_d && !pend_ok;
        pend_d     = pend_q;
        pend_pat_d = pend_pat_q;
        if (sel_ack_d) begin
            pend_d = 1'b0;
        end else if (i_sel_req && !pend_q && !sel_ack_q && !wait_low_q) begin
            pend_d     = 1'b1;
            pend_pat_d = i_sel_pat;
        end

        // A held request must drop for a cycle before it can be taken again
        wait_low_d = sel_ack_d ? 1'b1 : (i_sel_req ? wait_low_q : 1'b0);
    end

    always_comb begin
        o_pattern     = pattern_q;
        o_force_blank = (state_q != ST_RUN);
        o_link_up     = (state_q == ST_RUN);
        o_sel_ack     = sel_ack_q;
        o_sel_err     = sel_err_q;
    end

endmodule

// File: tb/tb_dvi_pattern_sched.sv
// tb/tb_dvi_pattern_sched.sv - bench for dvi_pattern_sched
module tb_dvi_pattern_sched;

    localparam int NUM_PATTERNS   = 6;
    localparam int PAT_W          = 4;
    localparam int FRAMES_PER_PAT = 2;
    localparam int WARMUP_FRAMES  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             locked;
    logic             vsync;
    logic             auto_en;
    logic             sel_req;
    logic [PAT_W-1:0] sel_pat;
    logic [PAT_W-1:0] pattern;
    logic             force_blank;
    logic             link_up;
    logic             sel_ack;
    logic             sel_err;

    int checks = 0;
    int errors = 0;
    bit cmp_model = 0;

    always #5 clk = ~clk;

    dvi_pattern_sched #(
        .NUM_PATTERNS   (NUM_PATTERNS),
        .PAT_W          (PAT_W),
        .FRAMES_PER_PAT (FRAMES_PER_PAT),
        .WARMUP_FRAMES  (WARMUP_FRAMES)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_locked      (locked),
        .i_vsync       (vsync),
        .i_auto_en     (auto_en),
        .i_sel_req     (sel_req),
        .i_sel_pat     (sel_pat),
        .o_pattern     (pattern),
        .o_force_blank (force_blank),
        .o_link_up     (link_up),
        .o_sel_ack     (sel_ack),
        .o_sel_err     (sel_err)
    );

    // Reference: mode 0 = waiting for lock, 1 = warming up, 2 = running
    int m_mode     = 0;
    int m_frames   = 0;
    int m_dwell    = 0;
    int m_pattern  = 0;
    bit m_pend     = 0;
    int m_pend_pat = 0;
    bit m_need_low = 0;
    bit m_ack      = 0;
    bit m_err      = 0;
    bit m_vs_prev  = 0;

    task automatic model_step();
        bit fb;
        bit latch;
        bit applied;
        fb = vsync && !m_vs_prev;
        if (rst) begin
            m_mode = 0; m_frames = 0; m_dwell = 0; m_pattern = 0;
            m_pend = 0; m_pend_pat = 0; m_need_low = 0;
            m_ack = 0; m_err = 0; m_vs_prev = 0;
            return;
        end
        m_vs_prev = vsync;
        latch = sel_req && !m_pend && !m_ack && !m_need_low;
        if (!sel_req) m_need_low = 0;
        m_ack = 0;
        m_err = 0;
        if (!locked) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_frames = 0;
        end else if (m_mode == 1) begin
            if (fb) begin
                m_frames++;
                if (m_frames == WARMUP_FRAMES) begin
                    m_mode = 2;
                    m_dwell = 0;
                end
            end
        end else if (fb) begin
            applied = 0;
            if (m_pend) begin
                m_ack = 1;
                m_pend = 0;
                m_need_low = 1;
                if (m_pend_pat < NUM_PATTERNS) begin
                    m_pattern = m_pend_pat;
                    m_dwell = 0;
                    applied = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (!applied && auto_en) begin
                m_dwell++;
                if (m_dwell == FRAMES_PER_PAT) begin
                    m_dwell = 0;
                    m_pattern = (m_pattern + 1) % NUM_PATTERNS;
                end
            end
        end
        if (latch) begin
            m_pend = 1;
            m_pend_pat = int'(sel_pat);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] a;
        logic [31:0] e;
        a = 32'({pattern, force_blank, link_up, sel_ack, sel_err});
        e = 32'({4'(m_pattern), 1'(m_mode != 2), 1'(m_mode == 2), m_ack, m_err});
        check("model {pat,blank,link,ack,err}", a, e);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (cmp_model) check_model();
    endtask

    task automatic frame(input int gap);
        vsync = 1'b0;
        repeat (gap) tick();
        vsync = 1'b1;
        tick();
    endtask

    task automatic frame_tail();
        repeat (3) tick();
        vsync = 1'b0;
    endtask

    typedef struct {
        logic             auto_en;
        logic             req;
        logic [PAT_W-1:0] pat;
        logic [PAT_W-1:0] exp_pat;
        logic             exp_ack;
        logic             exp_err;
    } vec_t;

    function automatic vec_t v(input bit a, input bit r, input int p, input int e,
                               input bit ack, input bit err);
        vec_t x;
        x.auto_en = a;
        x.req     = r;
        x.pat     = PAT_W'(p);
        x.exp_pat = PAT_W'(e);
        x.exp_ack = ack;
        x.exp_err = err;
        return x;
    endfunction

    vec_t vecs[$];

    initial begin
        int vs_cnt;
        int vs_gap;
        int lock_off;
        bit acked;

        // One row per frame: inputs held through the frame, outputs checked after its boundary
        vecs.push_back(v(1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 2, 0, 0));
        vecs.push_back(v(1, 0, 0, 2, 0, 0));
        vecs.push_back(v(1, 0, 0, 3, 0, 0));
        vecs.push_back(v(1, 0, 0, 3, 0, 0));
        vecs.push_back(v(1, 0, 0, 4, 0, 0));
        vecs.push_back(v(1, 0, 0, 4, 0, 0));
        vecs.push_back(v(1, 0, 0, 5, 0, 0));
        vecs.push_back(v(1, 0, 0, 5, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 5, 5, 1, 0));
        vecs.push_back(v(1, 1, 5, 5, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 9, 0, 1, 1));
        vecs.push_back(v(1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 1, 3, 3, 1, 0));
        vecs.push_back(v(1, 0, 0, 3, 0, 0));
        vecs.push_back(v(0, 1, 6, 3, 1, 1));
        vecs.push_back(v(0, 0, 0, 3, 0, 0));
        vecs.push_back(v(0, 1, 5, 5, 1, 0));
        vecs.push_back(v(1, 0, 0, 5, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0));

        rst = 1'b1; locked = 1'b1; vsync = 1'b0; auto_en = 1'b1;
        sel_req = 1'b0; sel_pat = '0;
        repeat (3) tick();
        check("reset pattern", 32'(pattern), 32'd0);
        check("reset force_blank", 32'(force_blank), 32'd1);
        check("reset link_up", 32'(link_up), 32'd0);
        check("reset sel_ack", 32'(sel_ack), 32'd0);
        check("reset sel_err", 32'(sel_err), 32'd0);

        rst = 1'b0;
        tick();
        for (int k = 0; k < WARMUP_FRAMES; k++) begin
            frame(96);
            check("warmup force_blank", 32'(force_blank), 32'(k < WARMUP_FRAMES - 1));
            check("warmup link_up", 32'(link_up), 32'(k == WARMUP_FRAMES - 1));
            frame_tail();
        end

        for (int i = 0; i < vecs.size(); i++) begin
            auto_en = vecs[i].auto_en;
            sel_req = vecs[i].req;
            sel_pat = vecs[i].pat;
            frame(30);
            check($sformatf("row%0d pattern", i), 32'(pattern), 32'(vecs[i].exp_pat));
            check($sformatf("row%0d sel_ack", i), 32'(sel_ack), 32'(vecs[i].exp_ack));
            check($sformatf("row%0d sel_err", i), 32'(sel_err), 32'(vecs[i].exp_err));
            tick();
            check($sformatf("row%0d ack pulse end", i), 32'(sel_ack), 32'd0);
            frame_tail();
        end
        sel_req = 1'b0;

        // Lock loss in RUN, request parked across warmup, pattern retained
        auto_en = 1'b0;
        tick();
        locked = 1'b0;
        check("lockloss blank not yet", 32'(force_blank), 32'd0);
        tick();
        check("lockloss force_blank", 32'(force_blank), 32'd1);
        check("lockloss link_up", 32'(link_up), 32'd0);
        sel_req = 1'b1; sel_pat = 4'd2;
        tick();
        locked = 1'b1;
        tick();
        for (int k = 0; k < WARMUP_FRAMES; k++) begin
            frame(30);
            check("relock link_up", 32'(link_up), 32'(k == WARMUP_FRAMES - 1));
            check("relock pattern held", 32'(pattern), 32'd0);
            check("relock no early ack", 32'(sel_ack), 32'd0);
            frame_tail();
        end
        frame(30);
        check("parked req pattern", 32'(pattern), 32'd2);
        check("parked req ack", 32'(sel_ack), 32'd1);
        frame_tail();
        sel_req = 1'b0;
        tick();

        cmp_model = 1;
        vs_cnt = 0; vs_gap = 25; lock_off = 0; acked = 0;
        for (int c = 0; c < 6000; c++) begin
            vs_cnt++;
            if (vs_cnt >= vs_gap) begin
                vs_cnt = 0;
                vs_gap = $urandom_range(8, 40);
            end
            vsync = (vs_cnt < 3);
            if (lock_off > 0) begin
                lock_off--;
                locked = (lock_off == 0);
            end else if ($urandom_range(0, 1499) == 0) begin
                lock_off = $urandom_range(1, 60);
                locked = 1'b0;
            end
            rst = ($urandom_range(0, 3999) == 0);
            if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
            if (sel_req) begin
                if (m_ack) acked = 1;
                if (acked && $urandom_range(0, 2) == 0) begin
                    sel_req = 1'b0;
                    acked = 0;
                end
            end else if ($urandom_range(0, 29) == 0) begin
                sel_req = 1'b1;
                sel_pat = PAT_W'($urandom_range(0, 7));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
